// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, ALU op codes and the arbiter lock states.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int CW   = 3;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SRL = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester handshakes, the ALU drive/return path and the
// response channel. slave = the arbiter, master = requesters/ALU/consumer.
interface alu_share_arbiter_if #(
    parameter int XLEN = 32,
    parameter int CW   = 3
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [CW-1:0]   req0_ctrl;
    logic            req0_lock;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [CW-1:0]   req1_ctrl;
    logic            req1_lock;

    logic [XLEN-1:0] alu_src_a;
    logic [XLEN-1:0] alu_src_b;
    logic [CW-1:0]   alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_lock,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_lock,
        output req1_ready,
        output alu_src_a, alu_src_b, alu_ctrl,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_lock,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_lock,
        input  req1_ready,
        input  alu_src_a, alu_src_b, alu_ctrl,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way grant logic: round-robin or req0-priority with a starvation guard
// that hands req1 the ALU after STARVE_LIMIT consecutive req0 wins.
module alu_rr_arb2 import alu_pkg::*; #(
    parameter bit FIXED_PRIO   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       can_issue,
    input  arb_state_e state,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       gnt0,
    output logic       gnt1
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic          rr_last;
    logic [SW-1:0] starve_cnt;
    logic          starved;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == LIMIT) ? v : v + 1'b1;
    endfunction

    assign starved = (starve_cnt == LIMIT);

    // Pick at most one winner; a held lock restricts the choice to its owner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_issue) begin
            case (state)
                LOCK0: gnt0 = req0_valid;
                LOCK1: gnt1 = req1_valid;
                default: begin
                    if (req0_valid && req1_valid) begin
                        if (FIXED_PRIO) begin
                            gnt0 = !starved;
                            gnt1 = starved;
                        end else begin
                            gnt0 = rr_last;
                            gnt1 = !rr_last;
                        end
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
                end
            endcase
        end
    end

    // Remember the most recent winner so a tie goes to the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
        end else if (gnt1) begin
            rr_last <= 1'b1;
        end
    end

    // Count req0 wins while req1 waits; held still while a lock is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == ARB) begin
            if (gnt1 || !req1_valid) begin
                starve_cnt <= '0;
            end else if (gnt0) begin
                starve_cnt <= sat_inc(starve_cnt);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external EX-stage ALU between two requesters. Holds the lock
// FSM, the operand mux towards the ALU and a one-entry tagged response
// register that captures the ALU output one cycle after acceptance.
module alu_share_arbiter #(
    parameter int XLEN         = alu_pkg::XLEN,
    parameter int CW           = alu_pkg::CW,
    parameter bit FIXED_PRIO   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    import alu_pkg::*;

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic            can_issue;
    logic            gnt0;
    logic            gnt1;
    logic            acc0;
    logic            acc1;

    logic            vld_p1;
    logic            id_p1;
    logic [XLEN-1:0] result_p1;
    logic            zero_p1;

    // A new op may start only if the response slot is free or draining now.
    assign can_issue = !vld_p1 || bus.rsp_ready;

    alu_rr_arb2 #(
        .FIXED_PRIO   (FIXED_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .can_issue  (can_issue),
        .state      (state_q),
        .req0_valid (bus.req0_valid),
        .req1_valid (bus.req1_valid),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign acc0 = bus.req0_valid && gnt0;
    assign acc1 = bus.req1_valid && gnt1;

    // Lock FSM: a locking accept pins the grant to that requester.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (acc0 && bus.req0_lock) begin
                    state_d = LOCK0;
                end else if (acc1 && bus.req1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: if (acc0 && !bus.req0_lock) state_d = ARB;
            LOCK1: if (acc1 && !bus.req1_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Route the winner's operands to the ALU; idle drive is ADD 0+0.
    always_comb begin
        bus.alu_src_a = '0;
        bus.alu_src_b = '0;
        bus.alu_ctrl  = '0;
        if (gnt0) begin
            bus.alu_src_a = bus.req0_a;
            bus.alu_src_b = bus.req0_b;
            bus.alu_ctrl  = bus.req0_ctrl;
        end else if (gnt1) begin
            bus.alu_src_a = bus.req1_a;
            bus.alu_src_b = bus.req1_b;
            bus.alu_ctrl  = bus.req1_ctrl;
        end
    end

    // ---- stage p1: response register, reloads on drain+accept ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            id_p1     <= 1'b0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
        end else if (acc0 || acc1) begin
            vld_p1    <= 1'b1;
            id_p1     <= acc1;
            result_p1 <= bus.alu_result;
            zero_p1   <= bus.alu_zero;
        end else if (bus.rsp_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign bus.rsp_valid  = vld_p1;
    assign bus.rsp_id     = id_p1;
    assign bus.rsp_result = result_p1;
    assign bus.rsp_zero   = zero_p1;

endmodule
